cacheline_adapter: RTL and testbench
====================================

Name: cacheline_adapter

Overview:
Sits directly downstream of the cache datapath, between the cache controller/datapath and physical memory. Converts one 256-bit line transfer (ram_line_i/ram_address_i/ram_line_o on the cache side) into a fixed-length burst of 64-bit beats on the memory side, and back. A single FSM handles reads (line fill) and writes (dirty write-back), with a one-cycle completion pulse to the cache controller.

Parameters:
s_line, 256, cache line width in bits
s_burst, 64, memory beat width in bits; num_beats = s_line/s_burst (4), beat counter width = $clog2(num_beats)
timeout_cycles, 1024, watchdog limit in cycles, used only when ADAPTER_TIMEOUT_EN is defined

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
line_i  input  s_line  write-back line from cache datapath
line_o  output  s_line  assembled fill line to cache datapath
address_i  input  32  line-aligned address from cache datapath
read_i  input  1  line read request, held until resp_o
write_i  input  1  line write request, held until resp_o
resp_o  output  1  one-cycle completion pulse
burst_i  input  s_burst  read beat from memory
burst_o  output  s_burst  write beat to memory
address_o  output  32  burst address to memory
read_o  output  1  memory burst read request
write_o  output  1  memory burst write request
resp_i  input  1  memory beat acknowledge (one per beat)
err_o  output  1  timeout pulse (tied 0 without ADAPTER_TIMEOUT_EN)

Behaviour:
- One clock, clk; reset rst is synchronous, active-high.
- Reset: state IDLE, beat counter 0, line_o = 0, read_o = write_o = resp_o = err_o = 0, address_o = 0, burst_o = 0.
- States: IDLE, READ_BURST, WRITE_BURST, DONE.
- IDLE: if write_i, latch address_i into address_o and line_i into the internal line buffer, then go to WRITE_BURST. Else if read_i, latch address_i and go to READ_BURST. If both are asserted (illegal), write wins.
- READ_BURST: read_o = 1. Each cycle with resp_i = 1 captures burst_i into line_o[count*s_burst +: s_burst] and increments count. When resp_i arrives on beat num_beats-1, go to DONE and reset count to 0.
- WRITE_BURST: write_o = 1; burst_o = buffer[count*s_burst +: s_burst] combinationally from count. Advance on resp_i; after the last beat, go to DONE.
- read_o and write_o stay high continuously through all beats and drop in the cycle after the last resp_i. Cycles with resp_i = 0 stall with no state change.
- DONE: resp_o = 1 for exactly one cycle, then IDLE. IDLE ignores read_i/write_i only in the DONE cycle itself. The controller deasserts its request on seeing resp_o, so no re-trigger occurs.
- Latency, zero-wait memory: request in IDLE at cycle 0; burst active cycles 1..4; resp_o at cycle 5.
- line_o holds its last completed fill until the next read burst starts overwriting beats. It is valid to consume when resp_o = 1.
- address_i changes after capture are ignored until the next IDLE capture.
- Reset mid-burst: abort immediately, apply all reset values, and issue no resp_o.
- resp_i in IDLE or DONE is ignored.

Optional Feature:
ADAPTER_TIMEOUT_EN
- Defined: a watchdog counter clears on every resp_i and on entry to a burst state, and increments each burst cycle without resp_i. On reaching timeout_cycles, the FSM aborts to DONE, and resp_o and err_o pulse together. line_o contents are then undefined-but-stable (partially filled).
- Undefined: no counter; err_o tied 0; a burst waits indefinitely.

Decomposition:
- The cache_types package gains adapter_state_t (IDLE, READ_BURST, WRITE_BURST, DONE) and a constant for the default beat count (4).
- Single module. The beat counter and watchdog are inline; no sub-module is warranted.

Test Plan:
- Read, zero-wait: read_i with address_i = 0x0000_1A20; burst_i = 0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp_i high 4 cycles -> address_o = 0x0000_1A20, read_o high 4 cycles, resp_o at cycle 5, line_o = {0x44..,0x33..,0x22..,0x11..}.
- Write with stalls: line_i = 256'hDDDD..CCCC..BBBB..AAAA, resp_i pattern 1,0,0,1,1,0,1 -> burst_o sequence AAAA, BBBB, CCCC, DDDD advancing only on resp_i; write_o held throughout; single resp_o.
- Simultaneous read_i and write_i in IDLE -> write burst taken, read_o stays 0.
- rst asserted after beat 2 of a read -> next cycle read_o = 0, line_o = 0, no resp_o; a subsequent read completes normally.
- Back-to-back: a write completes, then read_i is asserted the cycle after resp_o -> read starts from IDLE with no lost or duplicated beats.
- With ADAPTER_TIMEOUT_EN and timeout_cycles = 16: read with resp_i never asserted -> resp_o and err_o pulse together after 16 burst cycles, then IDLE.

Source files
------------

// File: rtl/cache_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_types (package)
// Description : Shared types and constants for the cache-to-memory adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_types;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_BURST  = 2'd1,
        WRITE_BURST = 2'd2,
        DONE        = 2'd3
    } adapter_state_t;

    localparam int unsigned c_DEFAULT_NUM_BEATS = 4;

endpackage : cache_types
`default_nettype wire

// File: rtl/cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_adapter
// Description : Splits a cache line into a fixed burst of memory beats (write)
//               and reassembles beats into a line (read). Optional watchdog
//               enabled by defining ADAPTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_adapter
    import cache_types::*;
#(
    parameter int unsigned S_LINE  = 256,
    parameter int unsigned S_BURST = 64
`ifdef ADAPTER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [S_LINE-1:0]  line_i,
    output logic [S_LINE-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [S_BURST-1:0] burst_i,
    output logic [S_BURST-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i,
    output logic               err_o
);

    localparam int unsigned        c_NUM_BEATS = S_LINE / S_BURST;
    localparam int unsigned        c_CNT_W     = (c_NUM_BEATS > 1) ? $clog2(c_NUM_BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_NUM_BEATS - 1);

    adapter_state_t     r_state;
    logic [c_CNT_W-1:0] r_count;
    logic [S_LINE-1:0]  r_line_buf;
    logic [S_LINE-1:0]  r_line;
    logic [31:0]        r_address;
    logic               r_read;
    logic               r_write;
    logic               r_resp;
    logic               w_in_burst;
    logic               w_timeout;

    assign w_in_burst = (r_state == READ_BURST) || (r_state == WRITE_BURST);

`ifdef ADAPTER_TIMEOUT_EN
    localparam int unsigned c_WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WD_W-1:0] r_wdog;
    logic              r_err;

    // Fires on the burst cycle that would be the TIMEOUT_CYCLES-th without a beat.
    assign w_timeout = w_in_burst && !resp_i && (r_wdog == c_WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (!w_in_burst || resp_i) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_line_buf <= '0;
            r_line     <= '0;
            r_address  <= '0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_resp     <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Write has priority when both requests are raised together.
                    if (write_i) begin
                        r_address  <= address_i;
                        r_line_buf <= line_i;
                        r_count    <= '0;
                        r_write    <= 1'b1;
                        r_state    <= WRITE_BURST;
                    end else if (read_i) begin
                        r_address <= address_i;
                        r_count   <= '0;
                        r_read    <= 1'b1;
                        r_state   <= READ_BURST;
                    end
                end
                READ_BURST: begin
                    if (resp_i) begin
                        r_line[r_count*S_BURST +: S_BURST] <= burst_i;
                        if (r_count == c_LAST_BEAT) begin
                            r_count <= '0;
                            r_read  <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_count <= '0;
                        r_read  <= 1'b0;
                        r_resp  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                WRITE_BURST: begin
                    if (resp_i) begin
                        if (r_count == c_LAST_BEAT) begin
                            r_count <= '0;
                            r_write <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_count <= '0;
                        r_write <= 1'b0;
                        r_resp  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign line_o    = r_line;
    assign burst_o   = r_line_buf[r_count*S_BURST +: S_BURST];
    assign address_o = r_address;
    assign read_o    = r_read;
    assign write_o   = r_write;
    assign resp_o    = r_resp;

endmodule : cacheline_adapter
`default_nettype wire

// File: tb/tb_cacheline_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_adapter
// Description : Self-checking bench for cacheline_adapter using a scoreboard
//               of expected write beats and fill lines.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_adapter;
    import cache_types::*;

    localparam int unsigned c_S_LINE  = 256;
    localparam int unsigned c_S_BURST = 64;
    localparam int unsigned c_BEATS   = c_DEFAULT_NUM_BEATS;

    logic                 clk;
    logic                 rst;
    logic [c_S_LINE-1:0]  line_i;
    logic [c_S_LINE-1:0]  line_o;
    logic [31:0]          address_i;
    logic                 read_i;
    logic                 write_i;
    logic                 resp_o;
    logic [c_S_BURST-1:0] burst_i;
    logic [c_S_BURST-1:0] burst_o;
    logic [31:0]          address_o;
    logic                 read_o;
    logic                 write_o;
    logic                 resp_i;
    logic                 err_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [c_S_BURST-1:0] exp_beats[$];
    logic [c_S_LINE-1:0]  exp_lines[$];
    logic [c_S_LINE-1:0]  last_line;

    cacheline_adapter #(
        .S_LINE  (c_S_LINE),
        .S_BURST (c_S_BURST)
`ifdef ADAPTER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One line transfer starting from IDLE at a negedge; stall_mask bit k
    // holds resp_i low in burst cycle k. Returns at the negedge of the
    // IDLE cycle following the completion pulse.
    task automatic run_txn(input bit wr, input bit both, input logic [31:0] addr,
                           input logic [255:0] data, input logic [31:0] stall_mask);
        int beat;
        int cyc;
        if (wr) begin
            for (int b = 0; b < c_BEATS; b++) exp_beats.push_back(data[b*c_S_BURST +: c_S_BURST]);
        end else begin
            exp_lines.push_back(data);
        end
        line_i    = wr ? data : rand_line();
        address_i = addr;
        write_i   = wr | both;
        read_i    = !wr | both;
        resp_i    = 1'b0;
        @(negedge clk);
        line_i    = rand_line();
        address_i = $urandom;
        chk("address_o", address_o, addr);
        beat = 0;
        cyc  = 0;
        while (beat < c_BEATS && cyc < 64) begin
            chk("read_o", read_o, !wr);
            chk("write_o", write_o, wr);
            chk("resp_o_busy", resp_o, 0);
            if (wr) begin
                if (exp_beats.size() == 0) chk("beat_queue", 0, 1);
                else chk("burst_o", burst_o, exp_beats[0]);
            end
            resp_i  = !stall_mask[cyc % 32];
            burst_i = resp_i ? data[beat*c_S_BURST +: c_S_BURST] : 64'($urandom) << 32 | 64'($urandom);
            if (resp_i) begin
                if (wr && exp_beats.size() != 0) void'(exp_beats.pop_front());
                beat++;
            end
            cyc++;
            @(negedge clk);
        end
        chk("beats_done", beat, c_BEATS);
        resp_i = 1'b0;
        chk("resp_o_done", resp_o, 1);
        chk("read_o_done", read_o, 0);
        chk("write_o_done", write_o, 0);
        chk("err_o", err_o, 0);
        if (!wr) begin
            if (exp_lines.size() == 0) chk("line_queue", 0, 1);
            else begin
                chk("line_o", line_o, exp_lines.pop_front());
                last_line = data;
            end
        end else begin
            chk("line_o_hold", line_o, last_line);
        end
        read_i  = 1'b0;
        write_i = 1'b0;
        @(negedge clk);
        chk("resp_o_pulse", resp_o, 0);
        chk("idle_read_o", read_o, 0);
    endtask

    initial begin
        int cyc;
        rst       = 1'b1;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        last_line = '0;
        repeat (3) @(negedge clk);
        chk("rst_line_o", line_o, 0);
        chk("rst_address_o", address_o, 0);
        chk("rst_burst_o", burst_o, 0);
        chk("rst_ctrl", {read_o, write_o, resp_o, err_o}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(0, 0, 32'h0000_1A20,
                {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}}, 32'h0);
        run_txn(1, 0, 32'h0000_3B40,
                {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}}, 32'h26);
        run_txn(1, 1, 32'h0000_5C60, rand_line(), 32'h0);

        // Reset in the middle of a read, after two beats.
        read_i    = 1'b1;
        address_i = 32'h0000_2040;
        @(negedge clk);
        resp_i  = 1'b1;
        burst_i = {4{16'h5555}};
        @(negedge clk);
        burst_i = {4{16'h6666}};
        @(negedge clk);
        resp_i = 1'b0;
        chk("mid_read_o", read_o, 1);
        rst    = 1'b1;
        read_i = 1'b0;
        @(negedge clk);
        chk("abort_read_o", read_o, 0);
        chk("abort_line_o", line_o, 0);
        chk("abort_address_o", address_o, 0);
        chk("abort_resp_o", resp_o, 0);
        rst       = 1'b0;
        last_line = '0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_resp", resp_o, 0);
        end
        run_txn(0, 0, 32'h0000_2040, rand_line(), 32'h5);

        // Back-to-back write then read, then a few randomized transfers.
        run_txn(1, 0, 32'h0000_7000, rand_line(), 32'h0);
        run_txn(0, 0, 32'h0000_7020, rand_line(), 32'h0);
        for (int i = 0; i < 6; i++) begin
            run_txn(bit'($urandom_range(0, 1)), 0, $urandom & 32'hFFFF_FFE0,
                    rand_line(), $urandom & 32'h0000_00FF);
        end

`ifdef ADAPTER_TIMEOUT_EN
        read_i    = 1'b1;
        address_i = 32'h0000_9000;
        resp_i    = 1'b0;
        @(negedge clk);
        cyc = 0;
        while (!resp_o && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("timeout_cycles", cyc, 16);
        chk("timeout_resp", resp_o, 1);
        chk("timeout_err", err_o, 1);
        chk("timeout_read_o", read_o, 0);
        read_i = 1'b0;
        @(negedge clk);
        chk("timeout_resp_clr", resp_o, 0);
        chk("timeout_err_clr", err_o, 0);
`else
        cyc = 0;
`endif

        chk("sb_beats_empty", exp_beats.size(), 0);
        chk("sb_lines_empty", exp_lines.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_cacheline_adapter
`default_nettype wire
